fp_add_arbiter: RTL
===================

# fp_add_arbiter

Shares one combinational `fp_adder` (IEEE-754 single precision, round-to-nearest-even, subnormals supported) between two independent requesters. The block uses round-robin arbitration and performs one operation at a time. It registers each granted request's operands, captures the adder output one cycle later, and returns the sum with a requester ID over a valid/ready response port. It sits between the two FP-issuing units of the multiplier datapath and the single shared adder instance.

## Interface
- `FIRST_PRIO`, default 0: requester that wins the first arbitration after reset (0 or 1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has an operation pending.
- `req0_ready`  out  1  requester 0's operation is accepted this cycle.
- `req0_a`, `req0_b`  in  32  operands, IEEE-754 single.
- `req0_sub`  in  1  1 = compute a − b (the sign bit of b is inverted before the adder).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_sub`: same as the requester 0 signals, for requester 1.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_sum`  out  32  IEEE-754 sum.
- `res_id`  out  1  requester that issued the operation.
- `busy`  out  1  state ≠ IDLE.
- `op_count`  out  16  completed operations (response handshakes), wraps at 0xFFFF→0.

## Operation
- The FSM has three states: IDLE, CALC, RESP.
- Internal registers: `op_a`, `op_b` (32 each), `op_id`, `last_grant`, `sum_q`.
- Both operand registers drive one `fp_adder` instance.
- IDLE arbitration:
  - If exactly one `reqX_valid` is high, grant X.
  - If both are high, grant `~last_grant`.
  - If neither is high, stay in IDLE.
- Ready is combinational: `reqX_ready = (state==IDLE) && reqX_valid && grant==X`. At most one ready is high in any cycle, and ready is never high outside IDLE.
- On accept (valid && ready), in one clock:
  - `op_a <= reqX_a`
  - `op_b <= {reqX_b[31]^reqX_sub, reqX_b[30:0]}`
  - `op_id <= X`
  - `last_grant <= X`
  - go to CALC
- CALC: `sum_q <= fp_adder.s`, then go to RESP. This is unconditional; the full cycle is the settling budget for the combinational adder.
- RESP:
  - `res_valid=1`, `res_sum=sum_q`, `res_id=op_id`.
  - On `res_ready`: `op_count` increments and the FSM goes to IDLE.
  - Otherwise it holds, with `res_sum` and `res_id` stable.
- The block never drops or reorders a request. Requesters must hold their inputs stable while valid && !ready.
- NaN/Inf inputs are passed through to the adder. The block has no special handling for them.

## Timing
- Reset values:
  - state = IDLE
  - `last_grant = ~FIRST_PRIO`
  - `op_a = op_b = sum_q = 0`
  - `op_id = 0`
  - `op_count = 0`
  - outputs `req*_ready = 0`, `res_valid = 0`, `res_sum = 0`, `res_id = 0`, `busy = 0`
- Latency: accept in cycle T gives `res_valid` high from cycle T+2.
- Best-case throughput is one operation per 3 cycles: accept, CALC, RESP with `res_ready` high. The next accept can happen in the cycle after the response handshake.
- `res_ready` held low: the FSM stays in RESP indefinitely, and both requesters see ready=0.
- A request arriving during CALC or RESP waits. It is arbitrated on the first IDLE cycle.
- Fairness: when both requesters are continuously valid, grants alternate 0,1,0,1…. Neither requester waits more than one other operation.
- A requester dropping valid in IDLE before it is granted is legal. Arbitration uses only the current-cycle valids.
- Reset asserted mid-operation (CALC or RESP): everything clears immediately (asynchronously). The in-flight result is discarded and `op_count` is not incremented.
- `op_count` increments only on the response handshake, wrapping 0xFFFF→0x0000.

## Test plan
- Single request: req0 a=0x3F800000, b=0x40000000, sub=0 accepted at T → `res_valid` at T+2 with `res_sum`=0x40400000, `res_id`=0, and `op_count`=1 after the handshake.
- Subtract: req1 a=0x40400000, b=0x3F800000, sub=1 → `res_sum`=0x40000000, `res_id`=1. Also req0 a=b=0x3F800001, sub=1 → 0x00000000.
- Simultaneous requests, FIRST_PRIO=0, both valid continuously for 4 operations → grant order 0,1,0,1. Only one ready is high per accept cycle, and the `res_id` sequence matches the grant order.
- Backpressure: hold `res_ready`=0 for 10 cycles in RESP → `res_sum` and `res_id` stable, `req*_ready`=0, `busy`=1. Release → one handshake, `op_count` +1.
- Mid-op reset: assert `rst_n`=0 during CALC → all outputs at reset values the same cycle, `op_count`=0. The next request after release is granted to requester FIRST_PRIO.
- Subnormal passthrough: a=0x00012832, b=0x8014283C, sub=0 → 0x8013000A. `op_count` wraps to 0 after 65536 completed operations.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: shares one combinational single-precision adder between two requesters.
//
// fp_adder       : combinational IEEE-754 binary32 adder, round-to-nearest-even, subnormals
//                  supported, NaN/Inf handled inside the adder only.
//   a, b         : operands
//   s            : a + b
//
// fp_add_arbiter : round-robin front end, one operation in flight at a time.
//   FIRST_PRIO   : requester that wins the first tie after reset
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   reqX_valid   : requester X has an operation pending
//   reqX_ready   : requester X's operation is accepted this cycle (combinational)
//   reqX_a/b     : operands
//   reqX_sub     : 1 = compute a - b
//   res_valid    : result available (held until res_ready)
//   res_ready    : consumer accepts the result
//   res_sum      : sum
//   res_id       : requester that issued the operation
//   busy         : an operation is in flight
//   op_count     : completed response handshakes, wraps at 16 bits

module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic        sl, ss;
    logic [7:0]  ea, eb, el, es, d, em1;
    logic [23:0] ml, msm, mant;
    logic [49:0] ms_wide;
    logic [26:0] ml_ext, ms_al, rn;
    logic [27:0] r;
    logic [4:0]  p, lz, sh;
    logic [8:0]  e_out;
    logic        rnd_up;
    logic [24:0] mant_r;
    logic [31:0] enc;

    always_comb begin
        sa    = a[31];
        sb    = b[31];
        ea    = a[30:23];
        eb    = b[30:23];
        a_nan = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b[22:0] == 23'd0);

        // Order operands so the larger magnitude is always "l".
        swap = b[30:0] > a[30:0];
        sl   = swap ? sb : sa;
        ss   = swap ? sa : sb;
        el   = swap ? eb : ea;
        es   = swap ? ea : eb;
        ml   = swap ? {eb != 8'd0, b[22:0]} : {ea != 8'd0, a[22:0]};
        msm  = swap ? {ea != 8'd0, a[22:0]} : {eb != 8'd0, b[22:0]};

        // Subnormals share exponent 1 with normals, just without the hidden bit.
        if (el == 8'd0) el = 8'd1;
        if (es == 8'd0) es = 8'd1;
        d = el - es;

        // Layout: 24-bit mantissa, guard, round, sticky.
        ml_ext  = {ml, 3'b000};
        ms_wide = {msm, 26'd0} >> d;
        if (d >= 8'd27) begin
            ms_al = {26'd0, |msm};
        end else begin
            ms_al = {ms_wide[49:24], |ms_wide[23:0]};
        end

        if (sl == ss) begin
            r = {1'b0, ml_ext} + {1'b0, ms_al};
        end else begin
            r = {1'b0, ml_ext} - {1'b0, ms_al};
        end

        p = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (r[i]) p = 5'(i);
        end
        lz  = 5'd26 - p;
        // Left shift is capped so the exponent never drops below 1 (subnormal result).
        em1 = el - 8'd1;
        sh  = (em1 < {3'b000, lz}) ? em1[4:0] : lz;

        if (r[27]) begin
            rn    = {r[27:2], r[1] | r[0]};
            e_out = {1'b0, el} + 9'd1;
        end else begin
            rn    = r[26:0] << sh;
            e_out = {1'b0, el} - {4'd0, sh};
        end

        mant   = rn[26:3];
        rnd_up = rn[2] & (rn[1] | rn[0] | mant[0]);
        mant_r = {1'b0, mant} + {24'd0, rnd_up};

        // Adding the mantissa (hidden bit included) onto (exp-1) lets a rounding carry or a
        // subnormal reaching 2^23 roll into the exponent field naturally.
        enc = (({23'd0, e_out} - 32'd1) << 23) + {7'd0, mant_r};
        if (enc >= 32'h7F80_0000) enc = 32'h7F80_0000;

        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            s = 32'h7FC0_0000;
        end else if (a_inf) begin
            s = a;
        end else if (b_inf) begin
            s = b;
        end else if (r == 28'd0) begin
            // Exact cancellation gives +0; only -0 + -0 keeps the sign.
            s = {sa & sb, 31'd0};
        end else begin
            s = {sl, enc[30:0]};
        end
    end
endmodule

module fp_add_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_sum,
    output logic        res_id,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e      state;
    logic [31:0] op_a, op_b, sum_q, adder_s;
    logic        op_id, last_grant, grant;
    logic [31:0] sel_a, sel_b;
    logic        sel_sub;

    fp_adder u_fp_adder (
        .a (op_a),
        .b (op_b),
        .s (adder_s)
    );

    // Ties go to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == StIdle) && req0_valid && !grant;
    assign req1_ready = (state == StIdle) && req1_valid && grant;

    assign sel_a   = grant ? req1_a : req0_a;
    assign sel_b   = grant ? req1_b : req0_b;
    assign sel_sub = grant ? req1_sub : req0_sub;

    assign res_valid = (state == StResp);
    assign res_sum   = sum_q;
    assign res_id    = op_id;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            sum_q      <= 32'd0;
            op_id      <= 1'b0;
            last_grant <= ~FIRST_PRIO;
            op_count   <= 16'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (req0_ready || req1_ready) begin
                        op_a       <= sel_a;
                        op_b       <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= StCalc;
                    end
                end
                StCalc: begin
                    // Full cycle of settling for the adder before capture.
                    sum_q <= adder_s;
                    state <= StResp;
                end
                StResp: begin
                    if (res_ready) begin
                        op_count <= op_count + 16'd1;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
